// File: rtl/mpu_irq_ctrl_if.sv
// Native picorv32-style memory bus between the CPU (master) and the interrupt
// controller (slave).
interface mpu_irq_ctrl_if;
  logic        i_valid;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [3:0]  i_wstrb;
  logic        o_ready;
  logic [31:0] o_rdata;
  logic        o_sel;

  modport master (
    output i_valid, i_addr, i_wdata, i_wstrb,
    input  o_ready, o_rdata, o_sel
  );

  modport slave (
    input  i_valid, i_addr, i_wdata, i_wstrb,
    output o_ready, o_rdata, o_sel
  );
endinterface

// File: rtl/mpu_irq_ctrl.sv
// Memory-mapped interrupt controller: synchronises event sources, latches or
// follows them per bit, masks them onto the CPU irq vector and retires on eoi.
module mpu_irq_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          NUM_SRC   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  mpu_irq_ctrl_if.slave      bus,
  input  logic [NUM_SRC-1:0] src_in,
  output logic [31:0]        irq,
  input  logic [31:0]        eoi
);

  localparam logic [31:0] SRC_MASK = (NUM_SRC >= 32) ? 32'hFFFF_FFFF
                                                      : ((32'h1 << NUM_SRC) - 32'h1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACK = 1'b1} state_t;

  function automatic logic [31:0] byte_mask(input logic [3:0] strb);
    byte_mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

  state_t      state_r, next_state_s;
  logic        accept_s, wr_s, sel_s;
  logic [5:0]  off_s;
  logic [31:0] wmask_s, wbits_s, rd_value_s, src_ext_s;
  logic [31:0] sync1_r, sync2_r, prev_r, eoi_prev_r;
  logic [31:0] pending_r, enable_r, edge_cfg_r, eoi_count_r, irq_r, rdata_r;
  logic [31:0] src_rise_s, eoi_rise_s, set_s, clr_s, pending_next_s;
  logic        unused_s;

  assign unused_s   = ^bus.i_addr[1:0];
  assign sel_s      = bus.i_valid && (bus.i_addr[31:8] == BASE_ADDR[31:8]);
  assign bus.o_sel  = sel_s;
  assign bus.o_ready = (state_r == ST_ACK);
  assign bus.o_rdata = rdata_r;
  assign irq        = irq_r;

  assign off_s      = bus.i_addr[7:2];
  assign wr_s       = accept_s && (bus.i_wstrb != 4'b0000);
  assign wmask_s    = byte_mask(bus.i_wstrb) & SRC_MASK;
  assign wbits_s    = bus.i_wdata & wmask_s;
  assign src_rise_s = sync2_r & ~prev_r;
  assign eoi_rise_s = eoi & ~eoi_prev_r;

  // Bus state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= next_state_s;
  end

  // Bus next state: accept only from IDLE, acknowledge for exactly one cycle
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (sel_s) begin
          accept_s     = 1'b1;
          next_state_s = ST_ACK;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ACK:  next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Source widening and register read mux (values before this cycle's update)
  always_comb begin
    src_ext_s = 32'h0;
    src_ext_s[NUM_SRC-1:0] = src_in;
    case (off_s)
      6'h00:   rd_value_s = pending_r;
      6'h01:   rd_value_s = enable_r;
      6'h03:   rd_value_s = edge_cfg_r;
      6'h04:   rd_value_s = pending_r & enable_r;
      6'h05:   rd_value_s = eoi_count_r;
      default: rd_value_s = 32'h0;
    endcase
  end

  // Pending update: set wins over clear in edge mode, level mode follows synced input
  always_comb begin
    set_s = src_rise_s;
    clr_s = eoi_rise_s;
    if (wr_s && (off_s == 6'h02)) begin
      set_s = src_rise_s | wbits_s;
    end else begin
      set_s = src_rise_s;
    end
    if (wr_s && (off_s == 6'h00)) begin
      clr_s = eoi_rise_s | wbits_s;
    end else begin
      clr_s = eoi_rise_s;
    end
    pending_next_s = ((((pending_r & ~clr_s) | set_s) & edge_cfg_r) |
                      (sync2_r & ~edge_cfg_r)) & SRC_MASK;
  end

  // Synchronisers, interrupt state and register writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r     <= 32'h0;
      sync2_r     <= 32'h0;
      prev_r      <= 32'h0;
      eoi_prev_r  <= 32'h0;
      pending_r   <= 32'h0;
      enable_r    <= 32'h0;
      edge_cfg_r  <= SRC_MASK;
      eoi_count_r <= 32'h0;
      irq_r       <= 32'h0;
      rdata_r     <= 32'h0;
    end else begin
      sync1_r    <= src_ext_s & SRC_MASK;
      sync2_r    <= sync1_r;
      prev_r     <= sync2_r;
      eoi_prev_r <= eoi;
      pending_r  <= pending_next_s;
      irq_r      <= pending_r & enable_r;
      rdata_r    <= accept_s ? rd_value_s : 32'h0;
      if (wr_s && (off_s == 6'h01)) begin
        enable_r <= (enable_r & ~wmask_s) | wbits_s;
      end
      if (wr_s && (off_s == 6'h03)) begin
        edge_cfg_r <= (edge_cfg_r & ~wmask_s) | wbits_s;
      end
      // A bus write to the counter takes priority over a coincident eoi edge
      if (wr_s && (off_s == 6'h05)) begin
        eoi_count_r <= (eoi_count_r & ~byte_mask(bus.i_wstrb)) |
                       (bus.i_wdata & byte_mask(bus.i_wstrb));
      end else if (eoi_rise_s != 32'h0) begin
        eoi_count_r <= eoi_count_r + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_mpu_irq_ctrl.sv
// Randomised bench for mpu_irq_ctrl: directed scenarios plus random traffic,
// every cycle compared against a rule-level reference model.
module tb_mpu_irq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] src_in;
  logic [31:0] eoi;
  logic [31:0] irq;
  int          n_checks = 0;
  int          n_fail   = 0;

  mpu_irq_ctrl_if bus ();

  mpu_irq_ctrl #(.BASE_ADDR(32'h8000_0000), .NUM_SRC(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .src_in(src_in), .irq(irq), .eoi(eoi)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: state after each clock edge, derived from the register rules
  logic [31:0] m_pend, m_en, m_edge, m_cnt, m_irq, m_rdata, d1, d2, d3, m_eoi_prev;
  logic        m_ready;

  always @(posedge clk or negedge rst_n) begin : model_p
    logic [31:0] rise, eoi_r, set, clr, pend_n, rd, wd;
    logic [5:0]  off;
    logic        acc, wr;
    if (!rst_n) begin
      m_pend <= 32'h0; m_en <= 32'h0; m_edge <= 32'hFFFF_FFFF; m_cnt <= 32'h0;
      m_irq <= 32'h0; m_rdata <= 32'h0; m_ready <= 1'b0;
      d1 <= 32'h0; d2 <= 32'h0; d3 <= 32'h0; m_eoi_prev <= 32'h0;
    end else begin
      acc = bus.i_valid && (bus.i_addr[31:8] == 24'h80_0000) && !m_ready;
      wr  = acc && (bus.i_wstrb != 4'b0000);
      off = bus.i_addr[7:2];
      wd  = bus.i_wdata;
      rd  = 32'h0;
      if (off == 6'h00) rd = m_pend;
      if (off == 6'h01) rd = m_en;
      if (off == 6'h03) rd = m_edge;
      if (off == 6'h04) rd = m_pend & m_en;
      if (off == 6'h05) rd = m_cnt;
      rise  = d2 & ~d3;
      eoi_r = eoi & ~m_eoi_prev;
      set = rise;
      clr = eoi_r;
      for (int b = 0; b < 4; b++) begin
        if (wr && bus.i_wstrb[b] && off == 6'h00) clr[b*8 +: 8] = clr[b*8 +: 8] | wd[b*8 +: 8];
        if (wr && bus.i_wstrb[b] && off == 6'h02) set[b*8 +: 8] = set[b*8 +: 8] | wd[b*8 +: 8];
      end
      for (int i = 0; i < 32; i++) begin
        if (!m_edge[i])   pend_n[i] = d2[i];
        else if (set[i])  pend_n[i] = 1'b1;
        else if (clr[i])  pend_n[i] = 1'b0;
        else              pend_n[i] = m_pend[i];
      end
      m_pend  <= pend_n;
      m_irq   <= m_pend & m_en;
      m_ready <= acc;
      m_rdata <= acc ? rd : 32'h0;
      for (int b = 0; b < 4; b++) begin
        if (wr && bus.i_wstrb[b] && off == 6'h01) m_en[b*8 +: 8]   <= wd[b*8 +: 8];
        if (wr && bus.i_wstrb[b] && off == 6'h03) m_edge[b*8 +: 8] <= wd[b*8 +: 8];
        if (wr && bus.i_wstrb[b] && off == 6'h05) m_cnt[b*8 +: 8]  <= wd[b*8 +: 8];
      end
      if (!(wr && off == 6'h05) && (eoi_r != 32'h0)) m_cnt <= m_cnt + 32'd1;
      d1 <= src_in; d2 <= d1; d3 <= d2;
      m_eoi_prev <= eoi;
    end
  end

  // Every-cycle comparison on the falling edge, while out of reset
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check_value("ready", {31'h0, bus.o_ready}, {31'h0, m_ready});
      check_value("rdata", bus.o_rdata, m_rdata);
      check_value("irq", irq, m_irq);
      check_value("sel", {31'h0, bus.o_sel},
                  {31'h0, bus.i_valid && (bus.i_addr[31:8] == 24'h80_0000)});
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic bus_xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] rd);
    int n;
    bus.i_valid = 1'b1; bus.i_addr = a; bus.i_wdata = d; bus.i_wstrb = s;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.o_ready && n < 6);
    if (a[31:8] == 24'h80_0000) check_value("bus_ack", {31'h0, bus.o_ready}, 32'h1);
    else                        check_value("oow_no_ack", {31'h0, bus.o_ready}, 32'h0);
    rd = bus.o_rdata;
    bus.i_valid = 1'b0; bus.i_wstrb = 4'b0000;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    bus_xfer(a, d, s, rd);
  endtask

  initial begin
    logic [31:0] rd, a;
    rst_n = 1'b0;
    bus.i_valid = 1'b0; bus.i_addr = 32'h0; bus.i_wdata = 32'h0; bus.i_wstrb = 4'h0;
    src_in = 32'h0; eoi = 32'h0;
    repeat (3) @(negedge clk);
    check_value("rst_irq", irq, 32'h0);
    check_value("rst_ready", {31'h0, bus.o_ready}, 32'h0);
    rst_n = 1'b1;
    tick();

    bus_xfer(32'h8000_000C, 32'h0, 4'h0, rd); check_value("edge_cfg_rst", rd, 32'hFFFF_FFFF);
    bus_xfer(32'h8000_0004, 32'h0, 4'h0, rd); check_value("enable_rst", rd, 32'h0);

    bus_wr(32'h8000_0004, 32'h1, 4'hF);
    src_in[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 3) src_in[0] = 1'b0;
      check_value("irq0_latency", {31'h0, irq[0]}, (k == 4) ? 32'h1 : 32'h0);
    end
    bus_xfer(32'h8000_0000, 32'h0, 4'h0, rd); check_value("pending_edge", rd, 32'h1);

    eoi[0] = 1'b1;
    tick(); tick();
    check_value("irq0_eoi", {31'h0, irq[0]}, 32'h0);
    eoi[0] = 1'b0;
    bus_xfer(32'h8000_0014, 32'h0, 4'h0, rd); check_value("eoi_count", rd, 32'h1);
    bus_xfer(32'h8000_0000, 32'h0, 4'h0, rd); check_value("pending_eoi", rd, 32'h0);

    bus_wr(32'h8000_000C, 32'h0, 4'hF);
    src_in[1] = 1'b1;
    bus_wr(32'h8000_0004, 32'h2, 4'hF);
    repeat (4) tick();
    check_value("irq1_level", {31'h0, irq[1]}, 32'h1);
    bus_wr(32'h8000_0000, 32'h2, 4'hF);
    bus_xfer(32'h8000_0000, 32'h0, 4'h0, rd); check_value("level_w1c_ignored", rd, 32'h2);
    src_in[1] = 1'b0;
    repeat (4) tick();
    check_value("irq1_level_drop", {31'h0, irq[1]}, 32'h0);
    bus_wr(32'h8000_000C, 32'hFFFF_FFFF, 4'hF);

    bus_wr(32'h8000_0004, 32'h0000_00AB, 4'b0001);
    bus_xfer(32'h8000_0004, 32'h0, 4'h0, rd); check_value("enable_byte", rd, 32'h0000_00AB);
    bus_xfer(32'h8000_0040, 32'h0, 4'h0, rd); check_value("unmapped_read", rd, 32'h0);

    src_in[2] = 1'b1;
    tick(); tick();
    bus_wr(32'h8000_0000, 32'h4, 4'hF);
    bus_xfer(32'h8000_0000, 32'h0, 4'h0, rd); check_value("set_beats_clear", rd, 32'h4);
    src_in[2] = 1'b0;

    bus_xfer(32'h9000_0000, 32'h0, 4'h0, rd); check_value("oow_rdata", rd, 32'h0);

    bus.i_valid = 1'b1; bus.i_addr = 32'h8000_0004; bus.i_wstrb = 4'h0;
    tick();
    check_value("mid_ack", {31'h0, bus.o_ready}, 32'h1);
    rst_n = 1'b0;
    #1;
    check_value("mid_rst_ready", {31'h0, bus.o_ready}, 32'h0);
    check_value("mid_rst_rdata", bus.o_rdata, 32'h0);
    bus.i_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 3) == 0) src_in = src_in ^ $urandom;
      if ($urandom_range(0, 2) == 0) eoi = $urandom & $urandom;
      if ($urandom_range(0, 1) == 0) begin
        tick();
      end else begin
        a = 32'h8000_0000 | ($urandom_range(0, 8) * 4);
        if ($urandom_range(0, 9) == 0) a = a ^ 32'h1000_0000;
        bus_xfer(a, $urandom, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)), rd);
      end
    end
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
